// File: rtl/fifo_write_ctrl_if.sv
// Write-side bus of a synchronous FIFO: push request, read pointer feedback, RAM lane ports, status.
// Latency: none, wires only.
// Backpressure: producer gates push_cnt on free_cnt; words beyond free space are dropped.
interface fifo_write_ctrl_if #(
   parameter int DEPTH    = 6,
   parameter int PUSH_MAX = 2
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int REQ_W = $clog2(PUSH_MAX + 1);

   logic [REQ_W-1:0]          push_cnt;
   logic [PTR_W-1:0]          r_ptr;
   logic                      clr_ovf;
   logic [PTR_W-1:0]          w_ptr;
   logic [PUSH_MAX*IDX_W-1:0] w_addr;
   logic [PUSH_MAX-1:0]       w_en;
   logic                      full;
   logic                      almost_full;
   logic [CNT_W-1:0]          free_cnt;
   logic                      overflow;

   // Producer / read-side view: drives requests and the read pointer.
   modport master (
      output push_cnt, r_ptr, clr_ovf,
      input  w_ptr, w_addr, w_en, full, almost_full, free_cnt, overflow
   );

   // Controller view.
   modport slave (
      input  push_cnt, r_ptr, clr_ovf,
      output w_ptr, w_addr, w_en, full, almost_full, free_cnt, overflow
   );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write pointer controller for arbitrary-depth FIFOs accepting up to PUSH_MAX words per cycle.
// Latency: zero-cycle acceptance (lane enables combinational); pointer/overflow registered.
// Backpressure: accepts min(request, free space); excess words are dropped and flag sticky overflow.
module fifo_write_ctrl #(
   parameter int DEPTH     = 6,
   parameter int PUSH_MAX  = 2,
   parameter int AF_THRESH = 4
) (
   input logic              clk,
   input logic              rst,
   fifo_write_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int REQ_W = $clog2(PUSH_MAX + 1);
   // Common width for comparing request against free space.
   localparam int AW    = (CNT_W > REQ_W) ? CNT_W : REQ_W;
   // Index plus one carry bit; holds w_idx + anything up to DEPTH without loss.
   localparam int SW    = IDX_W + 1;

   logic [PTR_W-1:0]          w_ptr_q;
   logic [PTR_W-1:0]          w_ptr_d;
   logic                      ovf_q;
   logic                      w_ph;
   logic                      r_ph;
   logic [IDX_W-1:0]          w_idx;
   logic [IDX_W-1:0]          r_idx;
   logic [CNT_W-1:0]          occ;
   logic [CNT_W-1:0]          free;
   logic [AW-1:0]             req;
   logic [AW-1:0]             free_a;
   logic [AW-1:0]             acc;
   logic                      ovf_set;
   logic [SW-1:0]             lane;
   logic [SW-1:0]             nxt_sum;
   logic [SW-1:0]             nxt_wrap;
   logic [PUSH_MAX-1:0]       w_en_c;
   logic [PUSH_MAX*IDX_W-1:0] w_addr_c;

   assign w_ph  = w_ptr_q[IDX_W];
   assign w_idx = w_ptr_q[IDX_W-1:0];
   assign r_ph  = bus.r_ptr[IDX_W];
   assign r_idx = bus.r_ptr[IDX_W-1:0];

   // Occupancy from registered write pointer and live read pointer; phase bit resolves wrap.
   always_comb begin
      occ = '0;
      if (w_ph == r_ph) begin
         occ = CNT_W'(w_idx) - CNT_W'(r_idx);
      end else begin
         occ = CNT_W'(DEPTH) - CNT_W'(r_idx) + CNT_W'(w_idx);
      end
      free = CNT_W'(DEPTH) - occ;
   end

   // Clamp the request, then accept only what fits; anything left over is an overflow.
   always_comb begin
      req = AW'(bus.push_cnt);
      if (req > AW'(PUSH_MAX)) begin
         req = AW'(PUSH_MAX);
      end
      free_a  = AW'(free);
      ovf_set = (req > free_a);
      acc     = ovf_set ? free_a : req;
   end

   // Per-lane RAM index wraps at DEPTH; addresses are driven regardless of enable.
   always_comb begin
      w_en_c   = '0;
      w_addr_c = '0;
      lane     = '0;
      for (int i = 0; i < PUSH_MAX; i++) begin
         lane = {1'b0, w_idx} + SW'(i);
         if (lane >= SW'(DEPTH)) begin
            lane = lane - SW'(DEPTH);
         end
         w_addr_c[i*IDX_W +: IDX_W] = lane[IDX_W-1:0];
         w_en_c[i]                  = (AW'(i) < acc);
      end
   end

   // Next write pointer: advance by accepted words, toggling phase when the index wraps.
   always_comb begin
      nxt_sum  = {1'b0, w_idx} + SW'(acc);
      nxt_wrap = nxt_sum - SW'(DEPTH);
      w_ptr_d  = w_ptr_q;
      if (nxt_sum >= SW'(DEPTH)) begin
         w_ptr_d = {~w_ph, nxt_wrap[IDX_W-1:0]};
      end else begin
         w_ptr_d = {w_ph, nxt_sum[IDX_W-1:0]};
      end
   end

   // Pointer and sticky overflow; a new overflow takes priority over a clear request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_ptr_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.w_ptr       = w_ptr_q;
   assign bus.w_addr      = w_addr_c;
   assign bus.w_en        = w_en_c;
   assign bus.full        = (occ == CNT_W'(DEPTH));
   assign bus.almost_full = (occ >= CNT_W'(AF_THRESH));
   assign bus.free_cnt    = free;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with DEPTH=6, PUSH_MAX=2, AF_THRESH=4.
// Latency: checks combinational outputs 1ns after input change, registered ones 1ns after the edge.
// Backpressure: exercises partial accept, push while full and request clamping.
module tb_fifo_write_ctrl;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fifo_write_ctrl_if #(.DEPTH(6), .PUSH_MAX(2)) bus ();

   fifo_write_ctrl #(.DEPTH(6), .PUSH_MAX(2), .AF_THRESH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] push, input logic [3:0] rp, input logic clr);
      bus.push_cnt = push;
      bus.r_ptr    = rp;
      bus.clr_ovf  = clr;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(2'd0, 4'd0, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'd0) begin n_err++; $display("FAIL reset_wptr got %0h want 0", bus.w_ptr); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", bus.overflow); end
      n_cmp++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_flags got full=%0b af=%0b want 0/0", bus.full, bus.almost_full); end
      n_cmp++; if (bus.free_cnt !== 3'd6) begin n_err++; $display("FAIL reset_free got %0d want 6", bus.free_cnt); end
      n_cmp++; if (bus.w_en !== 2'b00) begin n_err++; $display("FAIL reset_wen got %0b want 00", bus.w_en); end
      rst = 1'b1;
   endtask

   task automatic test_fill();
      logic [3:0] exp_ptr;
      for (int k = 0; k < 6; k++) begin
         drive(2'd1, 4'd0, 1'b0);
         n_cmp++; if (bus.w_en !== 2'b01) begin n_err++; $display("FAIL fill_wen[%0d] got %0b want 01", k, bus.w_en); end
         n_cmp++; if (bus.w_addr[2:0] !== 3'(k)) begin n_err++; $display("FAIL fill_addr[%0d] got %0d want %0d", k, bus.w_addr[2:0], k); end
         n_cmp++; if (bus.free_cnt !== 3'(6 - k)) begin n_err++; $display("FAIL fill_free[%0d] got %0d want %0d", k, bus.free_cnt, 6 - k); end
         n_cmp++; if (bus.almost_full !== (k >= 4)) begin n_err++; $display("FAIL fill_af[%0d] got %0b want %0b", k, bus.almost_full, k >= 4); end
         tick();
         exp_ptr = (k == 5) ? 4'b1000 : 4'(k + 1);
         n_cmp++; if (bus.w_ptr !== exp_ptr) begin n_err++; $display("FAIL fill_wptr[%0d] got %0h want %0h", k, bus.w_ptr, exp_ptr); end
      end
      n_cmp++; if (bus.full !== 1'b1 || bus.almost_full !== 1'b1) begin n_err++; $display("FAIL fill_flags got full=%0b af=%0b want 1/1", bus.full, bus.almost_full); end
      n_cmp++; if (bus.free_cnt !== 3'd0) begin n_err++; $display("FAIL fill_free_end got %0d want 0", bus.free_cnt); end
      n_cmp++; if (bus.w_en !== 2'b00) begin n_err++; $display("FAIL fill_full_wen got %0b want 00", bus.w_en); end
      drive(2'd0, 4'd0, 1'b0);
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf got %0b want 0", bus.overflow); end
   endtask

   task automatic test_wrap();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(2'd1, 4'd0, 1'b0);
         tick();
      end
      drive(2'd2, 4'b0010, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'b0101) begin n_err++; $display("FAIL wrap_start got %0h want 5", bus.w_ptr); end
      n_cmp++; if (bus.free_cnt !== 3'd3) begin n_err++; $display("FAIL wrap_free0 got %0d want 3", bus.free_cnt); end
      n_cmp++; if (bus.w_en !== 2'b11) begin n_err++; $display("FAIL wrap_wen got %0b want 11", bus.w_en); end
      n_cmp++; if (bus.w_addr !== 6'b000_101) begin n_err++; $display("FAIL wrap_addr got %0h want 05", bus.w_addr); end
      tick();
      drive(2'd0, 4'b0010, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'b1001) begin n_err++; $display("FAIL wrap_wptr got %0h want 9", bus.w_ptr); end
      n_cmp++; if (bus.free_cnt !== 3'd1) begin n_err++; $display("FAIL wrap_free1 got %0d want 1", bus.free_cnt); end
   endtask

   task automatic test_partial();
      drive(2'd2, 4'b0010, 1'b0);
      n_cmp++; if (bus.w_en !== 2'b01) begin n_err++; $display("FAIL part_wen got %0b want 01", bus.w_en); end
      tick();
      drive(2'd0, 4'b0010, 1'b1);
      n_cmp++; if (bus.w_ptr !== 4'b1010) begin n_err++; $display("FAIL part_wptr got %0h want a", bus.w_ptr); end
      n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL part_full got %0b want 1", bus.full); end
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL part_ovf got %0b want 1", bus.overflow); end
      tick();
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL part_clr got %0b want 0", bus.overflow); end
   endtask

   task automatic test_full_clr();
      drive(2'd1, 4'b0010, 1'b1);
      n_cmp++; if (bus.w_en !== 2'b00) begin n_err++; $display("FAIL fullclr_wen got %0b want 00", bus.w_en); end
      tick();
      drive(2'd0, 4'b0010, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'b1010) begin n_err++; $display("FAIL fullclr_wptr got %0h want a", bus.w_ptr); end
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fullclr_ovf got %0b want 1", bus.overflow); end
      drive(2'd0, 4'b0010, 1'b1);
      tick();
      drive(2'd0, 4'b0010, 1'b0);
   endtask

   task automatic test_clamp();
      drive(2'd3, 4'b1010, 1'b0);
      n_cmp++; if (bus.free_cnt !== 3'd6) begin n_err++; $display("FAIL clamp_free0 got %0d want 6", bus.free_cnt); end
      n_cmp++; if (bus.w_en !== 2'b11) begin n_err++; $display("FAIL clamp_wen got %0b want 11", bus.w_en); end
      n_cmp++; if (bus.w_addr !== 6'b011_010) begin n_err++; $display("FAIL clamp_addr got %0h want 1a", bus.w_addr); end
      tick();
      drive(2'd0, 4'b1010, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'b1100) begin n_err++; $display("FAIL clamp_wptr got %0h want c", bus.w_ptr); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL clamp_ovf got %0b want 0", bus.overflow); end
      n_cmp++; if (bus.free_cnt !== 3'd4) begin n_err++; $display("FAIL clamp_free1 got %0d want 4", bus.free_cnt); end
   endtask

   task automatic test_async_reset();
      // Walk to {1,3} keeping the FIFO empty, wrapping through phase 0.
      drive(2'd2, 4'b1100, 1'b0); tick();
      drive(2'd2, 4'b0000, 1'b0); tick();
      drive(2'd2, 4'b0010, 1'b0); tick();
      drive(2'd2, 4'b0100, 1'b0); tick();
      drive(2'd2, 4'b1000, 1'b0); tick();
      drive(2'd1, 4'b1010, 1'b0); tick();
      drive(2'd0, 4'b1011, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'b1011) begin n_err++; $display("FAIL arst_pre got %0h want b", bus.w_ptr); end
      // Make it full and push once more so overflow is set before the reset.
      drive(2'd1, 4'b0011, 1'b0);
      tick();
      drive(2'd0, 4'b0011, 1'b0);
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL arst_ovf_pre got %0b want 1", bus.overflow); end
      #1 rst = 1'b0;
      #1;
      n_cmp++; if (bus.w_ptr !== 4'd0) begin n_err++; $display("FAIL arst_wptr got %0h want 0", bus.w_ptr); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL arst_ovf got %0b want 0", bus.overflow); end
      drive(2'd0, 4'd0, 1'b0);
      rst = 1'b1;
      drive(2'd2, 4'd0, 1'b0);
      tick();
      drive(2'd0, 4'd0, 1'b0);
      n_cmp++; if (bus.w_ptr !== 4'd2) begin n_err++; $display("FAIL arst_resume got %0h want 2", bus.w_ptr); end
      n_cmp++; if (bus.free_cnt !== 3'd4) begin n_err++; $display("FAIL arst_free got %0d want 4", bus.free_cnt); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      bus.push_cnt = '0;
      bus.r_ptr    = '0;
      bus.clr_ovf  = 1'b0;
      #2;
      test_reset();
      tick();
      test_fill();
      test_wrap();
      test_partial();
      test_full_clr();
      test_clamp();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
